axi_memory_master_burst: RTL and testbench
==========================================

// Module: axi_memory_master_burst
// PURPOSE
// AXI4 burst master that turns one-cycle start_write/start_read requests into AXI write/read bursts.
// Sits between the frame memory_writer / memory_reader_noise_estimation controllers and the AXI memory slave.
// Write and read channels are independent; one instance may run a write and a read concurrently.
// Read data is not routed through this block: consumers take rdata directly from the slave, qualified by rvalid/rlast.
// PARAMETERS
// ADDR_WIDTH  32  address bus width
// DATA_WIDTH  32  data bus width; strobe width is DATA_WIDTH/8
// PORTS
// clk                                out/in as below
// clk          in   1            single clock, rising edge
// resetn       in   1            synchronous, active-high reset; name kept for codebase consistency
// start_write  in   1            one-cycle request for a write burst
// write_addr   in   ADDR_WIDTH   start address of the write burst
// write_len    in   32           write burst length in beats (1..256)
// write_size   in   3            beat size
// write_burst  in   2            burst type
// write_data   in   DATA_WIDTH   current write beat, held stable until the beat is accepted
// write_strb   in   DATA_WIDTH/8 current write byte strobes
// awaddr/awlen/awsize/awburst  out  ADDR_WIDTH/8/3/2  write address channel payload
// awvalid out 1 / awready in 1   write address handshake
// wdata out DATA_WIDTH / wstrb out DATA_WIDTH/8 / wlast out 1 / wvalid out 1 / wready in 1  write data channel
// bvalid in 1 / bready out 1     write response channel; bresp, if present, is ignored
// start_read   in   1            one-cycle request for a read burst
// read_addr    in   ADDR_WIDTH   start address of the read burst
// read_len     in   32           read burst length in beats
// read_size    in   3            beat size
// read_burst   in   2            burst type
// araddr/arlen/arsize/arburst  out  ADDR_WIDTH/8/3/2  read address channel payload
// arvalid out 1 / arready in 1   read address handshake
// rvalid in 1 / rlast in 1 / rready out 1  read data channel
// write_busy/read_busy  out 1    channel FSM is not idle
// write_done/read_done  out 1    one-cycle completion pulses
// BEHAVIOUR
// - Reset: all valid/ready/last/busy/done outputs are 0; all address/len/size/burst outputs are 0; both FSMs go to IDLE.
//   Reset in the middle of a burst abandons the burst immediately.
// - Write FSM: W_IDLE -> W_ADDR -> W_DATA -> W_RESP -> W_IDLE.
//   - W_IDLE: on start_write with write_len != 0, latch addr, len, size and burst.
//     awlen = write_len[7:0] - 1. awvalid = 1 in the next cycle.
//   - W_ADDR: hold awvalid and the AW payload stable until awvalid & awready. Then move to W_DATA and clear awvalid.
//   - W_DATA: wvalid = 1. wdata = write_data and wstrb = write_strb, combinational pass-through.
//     An 8-bit beat counter increments on each wvalid & wready.
//     wlast = 1 while the counter equals len-1.
//     The handshake on the last beat moves the FSM to W_RESP and clears wvalid.
//   - W_RESP: bready = 1. bvalid & bready pulses write_done for one cycle and returns the FSM to W_IDLE.
// - Read FSM: R_IDLE -> R_ADDR -> R_DATA -> R_IDLE.
//   - R_IDLE: on start_read with read_len != 0, latch addr, len, size and burst. arlen = read_len[7:0] - 1.
//   - R_ADDR: arvalid is held until arready.
//   - R_DATA: rready = 1. rvalid & rready & rlast pulses read_done for one cycle and returns the FSM to R_IDLE.
//     A beat counter is kept for debug only; termination is decided by rlast.
// - A start request while the matching FSM is not idle is ignored; it is not queued.
//   A request with len == 0 is ignored.
// - Requests with len > 256 are truncated to the low 8 bits of len.
// - start_write and start_read in the same cycle each launch their own burst.
// - awvalid/arvalid never drop before the handshake. All outputs except wdata/wstrb are registered.
// TESTING
// - W1: start_write addr=0x0, len=16, slave with awready/wready always 1 -> awlen=15, 16 wvalid beats, wlast only on beat 16, bready until bvalid, write_done pulses once.
// - W2: wready toggles every cycle during a len=4 burst -> wdata follows write_data, exactly 4 accepted beats, wlast held on beat 4 until accepted.
// - R1: start_read addr=0x40, len=8 -> arvalid with araddr=0x40 and arlen=7 until arready; rready high until rlast; read_done pulses; read_busy=0 next cycle.
// - C1: start_write and start_read in the same cycle (len 8 each) -> both bursts complete independently; a second start_read during R_DATA is ignored.
// - E1: start_write with len=0 -> no awvalid. resetn=1 mid-W_DATA -> wvalid=0 and W_IDLE next cycle.
// - E2: len=256 burst -> awlen=255, counter wraps cleanly, wlast on beat 256 only.

Source files
------------

// File: rtl/axi_memory_master_burst.sv
// AXI4 burst master: turns one-cycle start_write/start_read requests into
// independent AXI write and read bursts. Read data goes straight from slave to consumer.
module axi_memory_master_burst #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic                    clk,
    input  logic                    resetn,
    // write request side
    input  logic                    start_write,
    input  logic [ADDR_WIDTH-1:0]   write_addr,
    input  logic [31:0]             write_len,
    input  logic [2:0]              write_size,
    input  logic [1:0]              write_burst,
    input  logic [DATA_WIDTH-1:0]   write_data,
    input  logic [DATA_WIDTH/8-1:0] write_strb,
    // AXI write address channel
    output logic [ADDR_WIDTH-1:0]   awaddr,
    output logic [7:0]              awlen,
    output logic [2:0]              awsize,
    output logic [1:0]              awburst,
    output logic                    awvalid,
    input  logic                    awready,
    // AXI write data channel
    output logic [DATA_WIDTH-1:0]   wdata,
    output logic [DATA_WIDTH/8-1:0] wstrb,
    output logic                    wlast,
    output logic                    wvalid,
    input  logic                    wready,
    // AXI write response channel
    input  logic                    bvalid,
    output logic                    bready,
    // read request side
    input  logic                    start_read,
    input  logic [ADDR_WIDTH-1:0]   read_addr,
    input  logic [31:0]             read_len,
    input  logic [2:0]              read_size,
    input  logic [1:0]              read_burst,
    // AXI read address channel
    output logic [ADDR_WIDTH-1:0]   araddr,
    output logic [7:0]              arlen,
    output logic [2:0]              arsize,
    output logic [1:0]              arburst,
    output logic                    arvalid,
    input  logic                    arready,
    // AXI read data channel
    input  logic                    rvalid,
    input  logic                    rlast,
    output logic                    rready,
    // status
    output logic                    write_busy,
    output logic                    read_busy,
    output logic                    write_done,
    output logic                    read_done
);

    typedef enum logic [1:0] {W_IDLE, W_ADDR, W_DATA, W_RESP} wstate_t;
    typedef enum logic [1:0] {R_IDLE, R_ADDR, R_DATA} rstate_t;

    wstate_t    wstate;
    rstate_t    rstate;
    logic [7:0] wr_cnt;
    logic [7:0] rd_cnt;

    // Write beats are not registered: the producer holds write_data until accepted.
    assign wdata = write_data;
    assign wstrb = write_strb;

    always_ff @(posedge clk) begin
        if (resetn) begin
            wstate     <= W_IDLE;
            awaddr     <= '0;
            awlen      <= '0;
            awsize     <= '0;
            awburst    <= '0;
            awvalid    <= 1'b0;
            wvalid     <= 1'b0;
            wlast      <= 1'b0;
            bready     <= 1'b0;
            wr_cnt     <= '0;
            write_busy <= 1'b0;
            write_done <= 1'b0;
        end else begin
            write_done <= 1'b0;
            unique case (wstate)
                W_IDLE: begin
                    if (start_write && (write_len != 32'd0)) begin
                        awaddr     <= write_addr;
                        awlen      <= write_len[7:0] - 8'd1;
                        awsize     <= write_size;
                        awburst    <= write_burst;
                        awvalid    <= 1'b1;
                        write_busy <= 1'b1;
                        wstate     <= W_ADDR;
                    end
                end
                W_ADDR: begin
                    if (awready) begin
                        awvalid <= 1'b0;
                        wvalid  <= 1'b1;
                        wlast   <= (awlen == 8'd0);
                        wr_cnt  <= '0;
                        wstate  <= W_DATA;
                    end
                end
                W_DATA: begin
                    if (wready) begin
                        if (wlast) begin
                            wvalid <= 1'b0;
                            wlast  <= 1'b0;
                            bready <= 1'b1;
                            wstate <= W_RESP;
                        end else begin
                            // wlast is registered, so it looks one beat ahead of the counter
                            wr_cnt <= wr_cnt + 8'd1;
                            wlast  <= ((wr_cnt + 8'd1) == awlen);
                        end
                    end
                end
                W_RESP: begin
                    if (bvalid) begin
                        bready     <= 1'b0;
                        write_done <= 1'b1;
                        write_busy <= 1'b0;
                        wstate     <= W_IDLE;
                    end
                end
                default: wstate <= W_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (resetn) begin
            rstate    <= R_IDLE;
            araddr    <= '0;
            arlen     <= '0;
            arsize    <= '0;
            arburst   <= '0;
            arvalid   <= 1'b0;
            rready    <= 1'b0;
            rd_cnt    <= '0;
            read_busy <= 1'b0;
            read_done <= 1'b0;
        end else begin
            read_done <= 1'b0;
            unique case (rstate)
                R_IDLE: begin
                    if (start_read && (read_len != 32'd0)) begin
                        araddr    <= read_addr;
                        arlen     <= read_len[7:0] - 8'd1;
                        arsize    <= read_size;
                        arburst   <= read_burst;
                        arvalid   <= 1'b1;
                        read_busy <= 1'b1;
                        rstate    <= R_ADDR;
                    end
                end
                R_ADDR: begin
                    if (arready) begin
                        arvalid <= 1'b0;
                        rready  <= 1'b1;
                        rd_cnt  <= '0;
                        rstate  <= R_DATA;
                    end
                end
                R_DATA: begin
                    if (rvalid) begin
                        rd_cnt <= rd_cnt + 8'd1;
                        // the slave's rlast, not rd_cnt, ends the burst
                        if (rlast) begin
                            rready    <= 1'b0;
                            read_done <= 1'b1;
                            read_busy <= 1'b0;
                            rstate    <= R_IDLE;
                        end
                    end
                end
                default: rstate <= R_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_axi_memory_master_burst.sv
// Scoreboard bench for axi_memory_master_burst: directed bursts push expected AW/W/AR
// transfers and done pulses; a negedge monitor pops and compares as the DUT presents them.
module tb_axi_memory_master_burst;

    logic        clk = 1'b0;
    logic        resetn = 1'b1;
    logic        start_write = 1'b0;
    logic [31:0] write_addr = '0;
    logic [31:0] write_len = '0;
    logic [2:0]  write_size = '0;
    logic [1:0]  write_burst = '0;
    logic [31:0] write_data;
    logic [3:0]  write_strb = '0;
    logic [31:0] awaddr;
    logic [7:0]  awlen;
    logic [2:0]  awsize;
    logic [1:0]  awburst;
    logic        awvalid;
    logic        awready = 1'b0;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wlast, wvalid;
    logic        wready = 1'b0;
    logic        bvalid = 1'b0;
    logic        bready;
    logic        start_read = 1'b0;
    logic [31:0] read_addr = '0;
    logic [31:0] read_len = '0;
    logic [2:0]  read_size = '0;
    logic [1:0]  read_burst = '0;
    logic [31:0] araddr;
    logic [7:0]  arlen;
    logic [2:0]  arsize;
    logic [1:0]  arburst;
    logic        arvalid;
    logic        arready = 1'b0;
    logic        rvalid = 1'b0;
    logic        rlast = 1'b0;
    logic        rready;
    logic        write_busy, read_busy, write_done, read_done;

    axi_memory_master_burst #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
        .clk(clk), .resetn(resetn),
        .start_write(start_write), .write_addr(write_addr), .write_len(write_len),
        .write_size(write_size), .write_burst(write_burst),
        .write_data(write_data), .write_strb(write_strb),
        .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
        .awvalid(awvalid), .awready(awready),
        .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
        .bvalid(bvalid), .bready(bready),
        .start_read(start_read), .read_addr(read_addr), .read_len(read_len),
        .read_size(read_size), .read_burst(read_burst),
        .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
        .arvalid(arvalid), .arready(arready),
        .rvalid(rvalid), .rlast(rlast), .rready(rready),
        .write_busy(write_busy), .read_busy(read_busy),
        .write_done(write_done), .read_done(read_done)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;

    logic [44:0] aw_q[$];
    logic [36:0] w_q[$];
    logic [44:0] ar_q[$];
    bit          wd_q[$];
    bit          rd_q[$];

    // slave behaviour knobs
    int unsigned aw_delay = 0;
    int unsigned ar_delay = 0;
    bit          w_toggle = 1'b0;
    bit          r_gap = 1'b0;
    int unsigned r_total = 1;

    // write beat producer: data = wbase + beat index of the current burst
    int unsigned wb = 0;
    int unsigned wstart = 0;
    logic [31:0] wbase = '0;
    assign write_data = wbase + 32'(wb - wstart);

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- slave model ----------------
    initial begin
        int unsigned cnt = 0;
        forever begin
            @(posedge clk); #1;
            if (awvalid) begin awready = (cnt >= aw_delay); cnt++; end
            else begin awready = 1'b0; cnt = 0; end
        end
    end

    initial begin
        int unsigned cnt = 0;
        forever begin
            @(posedge clk); #1;
            if (arvalid) begin arready = (cnt >= ar_delay); cnt++; end
            else begin arready = 1'b0; cnt = 0; end
        end
    end

    initial forever begin
        @(posedge clk); #1;
        wready = w_toggle ? ~wready : 1'b1;
    end

    initial begin
        int unsigned cnt = 0;
        forever begin
            @(posedge clk); #1;
            if (bready) begin bvalid = (cnt >= 2); cnt++; end
            else begin bvalid = 1'b0; cnt = 0; end
        end
    end

    initial begin
        int unsigned sent = 0;
        bit hs;
        forever begin
            @(negedge clk);
            hs = rvalid && rready;
            @(posedge clk); #1;
            if (hs) sent = rlast ? 0 : sent + 1;
            if (rready) rvalid = r_gap ? ~rvalid : 1'b1;
            else        rvalid = 1'b0;
            rlast = rvalid && (sent == r_total - 1);
        end
    end

    initial begin
        bit hs;
        forever begin
            @(negedge clk);
            hs = wvalid && wready && !resetn;
            @(posedge clk); #1;
            if (hs) wb++;
        end
    end

    // ---------------- monitor ----------------
    initial forever begin
        @(negedge clk);
        if (!resetn) begin
            if (awvalid) begin
                if (aw_q.size() == 0) check("aw_spurious", awvalid, 0);
                else begin
                    check("aw_payload", {awaddr, awlen, awsize, awburst}, aw_q[0]);
                    if (awready) void'(aw_q.pop_front());
                end
            end
            if (wvalid) begin
                if (w_q.size() == 0) check("w_spurious", wvalid, 0);
                else begin
                    check("w_beat", {wdata, wstrb, wlast}, w_q[0]);
                    if (wready) void'(w_q.pop_front());
                end
            end
            if (arvalid) begin
                if (ar_q.size() == 0) check("ar_spurious", arvalid, 0);
                else begin
                    check("ar_payload", {araddr, arlen, arsize, arburst}, ar_q[0]);
                    if (arready) void'(ar_q.pop_front());
                end
            end
            if (write_done) begin
                if (wd_q.size() == 0) check("wdone_spurious", write_done, 0);
                else begin
                    void'(wd_q.pop_front());
                    check("wdone_busy_clear", write_busy, 0);
                end
            end
            if (read_done) begin
                if (rd_q.size() == 0) check("rdone_spurious", read_done, 0);
                else begin
                    void'(rd_q.pop_front());
                    check("rdone_busy_clear", read_busy, 0);
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic set_wr(input logic [31:0] addr, input logic [31:0] len, input logic [2:0] size,
                          input logic [1:0] burst, input logic [31:0] base, input logic [3:0] strb,
                          input logic [7:0] exp_awlen, input int unsigned exp_beats, input bit push);
        write_addr = addr; write_len = len; write_size = size; write_burst = burst;
        write_strb = strb; wbase = base; wstart = wb; start_write = 1'b1;
        if (push) begin
            aw_q.push_back({addr, exp_awlen, size, burst});
            for (int unsigned i = 0; i < exp_beats; i++)
                w_q.push_back({base + 32'(i), strb, (i == exp_beats - 1)});
            wd_q.push_back(1'b1);
        end
    endtask

    task automatic set_rd(input logic [31:0] addr, input logic [31:0] len, input logic [2:0] size,
                          input logic [1:0] burst, input logic [7:0] exp_arlen, input bit push);
        read_addr = addr; read_len = len; read_size = size; read_burst = burst; start_read = 1'b1;
        if (push) begin
            r_total = 32'(exp_arlen) + 1;
            ar_q.push_back({addr, exp_arlen, size, burst});
            rd_q.push_back(1'b1);
        end
    endtask

    task automatic end_start();
        @(posedge clk); #1;
        start_write = 1'b0;
        start_read  = 1'b0;
    endtask

    task automatic wait_idle(input int budget, input string name);
        bit ok = 1'b0;
        int n = 0;
        while (n < budget && !ok) begin
            @(negedge clk);
            ok = !write_busy && !read_busy && aw_q.size() == 0 && w_q.size() == 0 &&
                 ar_q.size() == 0 && wd_q.size() == 0 && rd_q.size() == 0;
            n++;
        end
        check(name, ok, 1);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_ctrl", {awvalid, wvalid, wlast, bready, arvalid, rready,
                             write_busy, read_busy, write_done, read_done}, 0);
        check("reset_aw", {awaddr, awlen, awsize, awburst}, 0);
        check("reset_ar", {araddr, arlen, arsize, arburst}, 0);
        @(posedge clk); #1 resetn = 1'b0;

        // W1: len 16, always-ready slave
        @(posedge clk); #1;
        set_wr(32'h0, 32'd16, 3'd2, 2'd1, 32'h1000_0000, 4'hF, 8'd15, 16, 1);
        end_start();
        wait_idle(200, "w1_complete");

        // W2: wready toggling, len 4
        w_toggle = 1'b1;
        @(posedge clk); #1;
        set_wr(32'h100, 32'd4, 3'd1, 2'd0, 32'h2000_0000, 4'h3, 8'd3, 4, 1);
        end_start();
        wait_idle(200, "w2_complete");
        w_toggle = 1'b0;

        // R1: arready after a delay, len 8
        ar_delay = 3;
        @(posedge clk); #1;
        set_rd(32'h40, 32'd8, 3'd2, 2'd1, 8'd7, 1);
        end_start();
        wait_idle(200, "r1_complete");

        // C1: concurrent write and read, extra read during R_DATA is dropped
        aw_delay = 2; ar_delay = 1; r_gap = 1'b1;
        @(posedge clk); #1;
        set_wr(32'h200, 32'd8, 3'd2, 2'd1, 32'h3000_0000, 4'hF, 8'd7, 8, 1);
        set_rd(32'h300, 32'd8, 3'd2, 2'd1, 8'd7, 1);
        end_start();
        begin
            int n = 0;
            while (n < 50 && !rready) begin @(negedge clk); n++; end
            check("c1_rdata_reached", rready, 1);
        end
        @(posedge clk); #1;
        set_rd(32'h80, 32'd4, 3'd2, 2'd1, 8'd3, 0);
        end_start();
        wait_idle(300, "c1_complete");
        aw_delay = 0; ar_delay = 0; r_gap = 1'b0;

        // E1a: zero-length write is ignored
        @(posedge clk); #1;
        set_wr(32'h400, 32'd0, 3'd2, 2'd1, 32'h4000_0000, 4'hF, 8'd0, 0, 0);
        end_start();
        repeat (4) begin
            @(negedge clk);
            check("len0_idle", {awvalid, write_busy}, 0);
        end

        // E1b: reset in the middle of W_DATA
        w_toggle = 1'b1;
        @(posedge clk); #1;
        set_wr(32'h500, 32'd8, 3'd2, 2'd1, 32'h5000_0000, 4'hF, 8'd7, 8, 1);
        end_start();
        begin
            int n = 0;
            while (n < 50 && !wvalid) begin @(negedge clk); n++; end
            check("e1_wdata_reached", wvalid, 1);
        end
        repeat (3) @(posedge clk);
        #1 resetn = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("e1_reset_abort", {wvalid, wlast, awvalid, bready, write_busy}, 0);
        aw_q.delete(); w_q.delete(); wd_q.delete();
        @(posedge clk); #1 resetn = 1'b0;
        w_toggle = 1'b0;

        // truncation: len 0x105 -> low byte 5 beats
        @(posedge clk); #1;
        set_wr(32'h600, 32'h105, 3'd2, 2'd1, 32'h6000_0000, 4'hC, 8'd4, 5, 1);
        end_start();
        wait_idle(100, "trunc_complete");

        // E2: 256-beat burst
        @(posedge clk); #1;
        set_wr(32'h1000, 32'd256, 3'd2, 2'd1, 32'h7000_0000, 4'hF, 8'd255, 256, 1);
        end_start();
        wait_idle(700, "e2_complete");

        repeat (3) @(negedge clk);
        check("drain_queues", aw_q.size() + w_q.size() + ar_q.size() + wd_q.size() + rd_q.size(), 0);
        check("final_idle", {write_busy, read_busy, awvalid, wvalid, arvalid, bready, rready}, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
